// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two circular prefetch queue with registered head and synchronous flush.
module sync_fifo #(
    parameter int WIDTH_DATA = 64,
    parameter int DEPTH      = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [WIDTH_DATA-1:0] push_data_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [CW-1:0]         count_o,
    output logic                  head_valid_o,
    output logic [WIDTH_DATA-1:0] head_data_o
);

    logic [WIDTH_DATA-1:0] mem_q [DEPTH];
    logic [AW-1:0]         rd_ptr_q;
    logic [AW-1:0]         wr_ptr_q;
    logic [CW-1:0]         count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            // Flush wins over any same-cycle push or pop.
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_unit.sv
// Fetch PC owner: single-outstanding imem requests feeding a prefetch queue,
// with flush/refetch on EX redirects.
module ifetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_en,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    input  logic             out_ready,
    output fetch_state_t     dbg_state
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [WIDTH-1:0] INC   = WIDTH'(INSTR_BYTES);

    fetch_state_t     state_q;
    logic [WIDTH-1:0] fetch_pc_q;
    logic [WIDTH-1:0] req_addr_q;

    logic [CW-1:0]      count;
    logic [CW-1:0]      count_d;
    logic               head_valid;
    logic [2*WIDTH-1:0] head_data;
    logic               push;
    logic               pop;
    logic               has_room;
    logic [WIDTH-1:0]   target;
    logic [WIDTH-1:0]   seq_pc;
    logic               unused_pc_bits;

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = req_addr_q;

    assign pop    = head_valid && out_ready;
    assign push   = (state_q == FETCH) && imem_ack && !redirect_en;
    assign target = {redirect_pc[WIDTH-1:2], 2'b00};
    assign seq_pc = req_addr_q + INC;

    // Occupancy after this cycle's pop/push decides whether another slot may be reserved.
    assign count_d  = count + CW'(push) - CW'(pop);
    assign has_room = (count_d < DEPTH_C);

    assign unused_pc_bits = &redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else if (redirect_en) begin
            fetch_pc_q <= target;
            // An access already on the bus must still complete; DRAIN swallows its data.
            if (state_q == IDLE || imem_ack) begin
                state_q    <= FETCH;
                req_addr_q <= target;
            end else begin
                state_q <= DRAIN;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (has_room) begin
                        state_q    <= FETCH;
                        req_addr_q <= fetch_pc_q;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        fetch_pc_q <= seq_pc;
                        if (has_room) begin
                            req_addr_q <= seq_pc;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state_q    <= FETCH;
                        req_addr_q <= fetch_pc_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH_DATA (2 * WIDTH),
        .DEPTH      (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_data_i  ({req_addr_q, imem_rdata}),
        .pop_i        (pop),
        .flush_i      (redirect_en),
        .count_o      (count),
        .head_valid_o (head_valid),
        .head_data_o  (head_data)
    );

    assign out_valid = head_valid;
    assign out_pc    = head_data[2*WIDTH-1:WIDTH];
    assign out_instr = head_data[WIDTH-1:0];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus random traffic
// against a transaction-level model of the fetch queue.
module tb_ifetch_unit;
  import fetch_pkg::*;

  localparam int W = 32;
  localparam int D = 4;
  localparam logic [W-1:0] RPC = 32'h0000_0000;

  logic         clk;
  logic         rst;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ack;
  logic [W-1:0] imem_rdata;
  logic         redirect_en;
  logic [W-1:0] redirect_pc;
  logic         out_valid;
  logic [W-1:0] out_instr;
  logic [W-1:0] out_pc;
  logic         out_ready;
  fetch_state_t dbg_state;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ifetch_unit #(.WIDTH(W), .DEPTH(D), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready),
    .dbg_state   (dbg_state)
  );

  int n_checks;
  int n_errors;

  // reference model: queued {pc, instr} entries plus the outstanding access
  logic [2*W-1:0] exp_q[$];
  bit             m_busy;
  bit             m_discard;
  logic [W-1:0]   m_addr;
  logic [W-1:0]   m_fetch_pc;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_busy     = 1'b0;
    m_discard  = 1'b0;
    m_addr     = RPC;
    m_fetch_pc = RPC;
  endtask

  task automatic model_step(input bit ack, input bit rdy, input bit redir,
                            input logic [W-1:0] rpc, input logic [W-1:0] rdata);
    logic [W-1:0] tgt;
    bit popped;
    tgt    = rpc & ~32'h3;
    popped = (exp_q.size() != 0) && rdy;
    if (redir) begin
      exp_q.delete();
      m_fetch_pc = tgt;
      if (!m_busy || ack) begin
        m_busy    = 1'b1;
        m_discard = 1'b0;
        m_addr    = tgt;
      end else begin
        m_discard = 1'b1;
      end
    end else begin
      if (popped) void'(exp_q.pop_front());
      if (m_busy && ack) begin
        if (m_discard) begin
          m_discard = 1'b0;
          m_addr    = m_fetch_pc;
        end else begin
          exp_q.push_back({m_addr, rdata});
          m_fetch_pc = m_addr + 4;
          if (exp_q.size() < D) m_addr = m_addr + 4;
          else m_busy = 1'b0;
        end
      end else if (!m_busy && exp_q.size() < D) begin
        m_busy = 1'b1;
        m_addr = m_fetch_pc;
      end
    end
  endtask

  // driver: called at a falling edge; checks outputs, drives inputs, advances one clock
  task automatic cycle(input bit ack, input bit rdy, input bit redir, input logic [W-1:0] rpc);
    logic [W-1:0] rdata;
    check("imem_req", W'(imem_req), W'(m_busy));
    if (m_busy) check("imem_addr", imem_addr, m_addr);
    check("out_valid", W'(out_valid), W'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_pc", out_pc, exp_q[0][2*W-1:W]);
      check("out_instr", out_instr, exp_q[0][W-1:0]);
    end
    rdata       = $urandom;
    imem_ack    = ack;
    out_ready   = rdy;
    redirect_en = redir;
    redirect_pc = rpc;
    imem_rdata  = rdata;
    model_step(ack, rdy, redir, rpc, rdata);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst         = 1'b0;
    imem_ack    = 1'b0;
    out_ready   = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    #1;
    check("rst_req", W'(imem_req), '0);
    check("rst_addr", imem_addr, RPC);
    check("rst_valid", W'(out_valid), '0);
    check("rst_instr", out_instr, '0);
    check("rst_pc", out_pc, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rpc;
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b0;
    imem_rdata = '0;
    model_reset();
    do_reset();

    // zero-wait memory, consumer always ready
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, '0);
    check("stream_pc", out_pc, 32'h4);
    check("stream_addr", imem_addr, 32'h8);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, '0);

    // stalled consumer fills the queue, one pop reserves exactly one slot
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, '0);
    check("full_req", W'(imem_req), '0);
    check("full_head", out_pc, 32'h0);
    cycle(1, 1, 0, '0);
    check("refill_req", W'(imem_req), 32'h1);
    check("refill_addr", imem_addr, 32'h10);
    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, '0);

    // asynchronous reset with a request outstanding and a non-empty queue
    do_reset();

    // redirect during a slow access: drained, then refetch at target
    cycle(0, 1, 0, '0);
    cycle(0, 1, 0, '0);
    cycle(0, 1, 1, 32'h40);
    check("drain_hold_addr", imem_addr, 32'h0);
    check("drain_hold_req", W'(imem_req), 32'h1);
    cycle(0, 1, 0, '0);
    cycle(1, 1, 0, '0);
    check("drain_new_addr", imem_addr, 32'h40);
    check("drain_no_stale", W'(out_valid), '0);
    cycle(1, 1, 0, '0);
    check("drain_first_pc", out_pc, 32'h40);

    // redirect with concurrent ack and pop on a two-entry queue
    do_reset();
    cycle(0, 0, 0, '0);
    cycle(1, 0, 0, '0);
    cycle(1, 0, 0, '0);
    cycle(1, 1, 1, 32'h103);
    check("redir_valid", W'(out_valid), '0);
    check("redir_addr", imem_addr, 32'h100);

    // two redirects within one drain: newest target wins
    cycle(0, 1, 1, 32'h80);
    cycle(0, 1, 1, 32'hC0);
    cycle(1, 1, 0, '0);
    check("double_redir_addr", imem_addr, 32'hC0);

    // sequential PC wraps modulo 2^W
    cycle(0, 1, 1, 32'hFFFF_FFFF);
    cycle(1, 1, 0, '0);
    check("wrap_top", imem_addr, 32'hFFFF_FFFC);
    cycle(1, 1, 0, '0);
    check("wrap_zero", imem_addr, 32'h0);
    cycle(1, 1, 0, '0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, rpc);
      if (i == 1500) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
